// File: rtl/mod_updown_counter_pkg.sv
// Shared constants and types for the up/down counter and its incrementer.
package mod_updown_counter_pkg;

   localparam int unsigned MODE_WRAP = 0;
   localparam int unsigned MODE_SAT  = 1;
   localparam int unsigned CLA_GROUP = 4;

   localparam int unsigned DEF_WIDTH   = 8;
   localparam int unsigned DEF_MODULUS = 256;
   localparam int unsigned DEF_MAX_VAL = DEF_MODULUS - 1;

   // Per-cycle action after priority resolution (clear > load > enable).
   typedef enum logic [1:0] {
      ACT_HOLD,
      ACT_CLEAR,
      ACT_LOAD,
      ACT_STEP
   } act_e;

endpackage

// File: rtl/mod_updown_counter_cla_incdec.sv
// Carry-lookahead +1 / -1 unit built from 4-bit generate/propagate groups.
module cla_incdec
   import mod_updown_counter_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic [WIDTH-1:0] operand,
   input  logic             dec,
   input  logic             cin,
   output logic [WIDTH-1:0] result,
   output logic             cout
);

   localparam int unsigned NGRP = (WIDTH + CLA_GROUP - 1) / CLA_GROUP;
   localparam int unsigned PW   = NGRP * CLA_GROUP;

   logic [WIDTH-1:0] ndec;
   logic [PW-1:0]    a, b, g, p, c;

   // Pad bits get a=0, b=1 so the carry into bit WIDTH ripples straight to the top group.
   assign ndec = {WIDTH{~dec}};
   assign a    = PW'(operand);
   assign b    = ~PW'(ndec);
   assign g    = a & b;
   assign p    = a ^ b;

   for (genvar k = 0; k < NGRP; k++) begin : g_grp
      localparam int unsigned B = k * CLA_GROUP;
      logic ci, co, gg, gp;

      if (k == 0) begin : g_first
         assign ci = cin;
      end else begin : g_next
         assign ci = g_grp[k-1].co;
      end

      assign gg = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1]) |
                  (p[B+3] & p[B+2] & p[B+1] & g[B]);
      assign gp = &p[B+3:B];

      assign c[B]   = ci;
      assign c[B+1] = g[B] | (p[B] & ci);
      assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & ci);
      assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B]) |
                      (p[B+2] & p[B+1] & p[B] & ci);
      assign co     = gg | (gp & ci);
   end

   assign result = WIDTH'(p ^ c);
   assign cout   = g_grp[NGRP-1].co;

endmodule

// File: rtl/mod_updown_counter.sv
// Parametrised up/down counter with clear, load, wrap/saturate and terminal flags.
module mod_updown_counter
   import mod_updown_counter_pkg::*;
#(
   parameter int unsigned      WIDTH    = DEF_WIDTH,
   parameter longint unsigned  MODULUS  = DEF_MODULUS,
   parameter int unsigned      SATURATE = MODE_WRAP
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   input  logic             up_down,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             clear,
   output logic [WIDTH-1:0] value_out,
   output logic             carry_out,
   output logic             borrow_out,
   output logic             overflow,
   output logic             at_max,
   output logic             at_zero
);

   typedef logic [WIDTH-1:0] count_t;

   localparam count_t MAX_VAL = WIDTH'(MODULUS - 64'd1);
   localparam bit     POW2    = (MODULUS == (64'd1 << WIDTH));
   localparam bit     SAT     = (SATURATE == MODE_SAT);

   count_t value_q, value_d;
   logic   carry_q, carry_d;
   logic   borrow_q, borrow_d;
   logic   ovf_q, ovf_d;

   count_t step_val;
   logic   step_cout;
   logic   up_wrap, dn_wrap, wrap_hit;
   count_t wrap_val;
   act_e   act;

   cla_incdec #(.WIDTH(WIDTH)) u_incdec (
      .operand (value_q),
      .dec     (~up_down),
      .cin     (up_down),
      .result  (step_val),
      .cout    (step_cout)
   );

   // Full-range counters use the adder carry; reduced ranges compare against the ends.
   always_comb begin
      up_wrap = (value_q == MAX_VAL);
      dn_wrap = (value_q == '0);
      if (POW2) begin
         up_wrap = step_cout;
         dn_wrap = ~step_cout;
      end
      wrap_hit = up_down ? up_wrap : dn_wrap;
      wrap_val = up_down ? '0 : MAX_VAL;
   end

   always_comb begin
      act      = ACT_HOLD;
      value_d  = value_q;
      carry_d  = 1'b0;
      borrow_d = 1'b0;
      ovf_d    = ovf_q;

      if (clear)       act = ACT_CLEAR;
      else if (load)   act = ACT_LOAD;
      else if (enable) act = ACT_STEP;

      case (act)
         ACT_CLEAR: begin
            value_d = '0;
            ovf_d   = 1'b0;
         end
         ACT_LOAD: begin
            value_d = (load_value > MAX_VAL) ? MAX_VAL : load_value;
         end
         ACT_STEP: begin
            if (!wrap_hit) begin
               value_d = step_val;
            end else if (SAT) begin
               ovf_d = 1'b1;
            end else begin
               value_d  = wrap_val;
               carry_d  = up_down;
               borrow_d = ~up_down;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         value_q  <= '0;
         carry_q  <= 1'b0;
         borrow_q <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         value_q  <= value_d;
         carry_q  <= carry_d;
         borrow_q <= borrow_d;
         ovf_q    <= ovf_d;
      end
   end

   assign value_out  = value_q;
   assign carry_out  = carry_q;
   assign borrow_out = borrow_q;
   assign overflow   = ovf_q;
   assign at_max     = (value_q == MAX_VAL);
   assign at_zero    = (value_q == '0);

endmodule

// File: tb/tb_mod_updown_counter.sv
// Five counter configurations driven by shared stimulus and checked against an arithmetic model.
module tb_mod_updown_counter;

   localparam int N = 5;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        enable = 1'b0, up_down = 1'b0, load = 1'b0, clear = 1'b0;
   logic [11:0] lv = '0;

   logic [7:0]  v8 [3];
   logic [11:0] v12 [2];
   logic [11:0] d_val [N];
   logic        d_c [N], d_b [N], d_o [N], d_mx [N], d_z [N];

   int unsigned p_mod [N] = '{256, 10, 10, 3000, 3000};
   bit          p_sat [N] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
   int unsigned p_w   [N] = '{8, 8, 8, 12, 12};

   int unsigned m_val [N];
   bit          m_c [N], m_b [N], m_o [N];

   int  checks = 0;
   int  errors = 0;
   bit  chk_en = 1'b0;

   always #5 clock = ~clock;

   mod_updown_counter #(.WIDTH(8), .MODULUS(256), .SATURATE(0)) u0 (
      .clock(clock), .reset(reset), .enable(enable), .up_down(up_down), .load(load),
      .load_value(lv[7:0]), .clear(clear), .value_out(v8[0]), .carry_out(d_c[0]),
      .borrow_out(d_b[0]), .overflow(d_o[0]), .at_max(d_mx[0]), .at_zero(d_z[0]));
   mod_updown_counter #(.WIDTH(8), .MODULUS(10), .SATURATE(0)) u1 (
      .clock(clock), .reset(reset), .enable(enable), .up_down(up_down), .load(load),
      .load_value(lv[7:0]), .clear(clear), .value_out(v8[1]), .carry_out(d_c[1]),
      .borrow_out(d_b[1]), .overflow(d_o[1]), .at_max(d_mx[1]), .at_zero(d_z[1]));
   mod_updown_counter #(.WIDTH(8), .MODULUS(10), .SATURATE(1)) u2 (
      .clock(clock), .reset(reset), .enable(enable), .up_down(up_down), .load(load),
      .load_value(lv[7:0]), .clear(clear), .value_out(v8[2]), .carry_out(d_c[2]),
      .borrow_out(d_b[2]), .overflow(d_o[2]), .at_max(d_mx[2]), .at_zero(d_z[2]));
   mod_updown_counter #(.WIDTH(12), .MODULUS(3000), .SATURATE(0)) u3 (
      .clock(clock), .reset(reset), .enable(enable), .up_down(up_down), .load(load),
      .load_value(lv), .clear(clear), .value_out(v12[0]), .carry_out(d_c[3]),
      .borrow_out(d_b[3]), .overflow(d_o[3]), .at_max(d_mx[3]), .at_zero(d_z[3]));
   mod_updown_counter #(.WIDTH(12), .MODULUS(3000), .SATURATE(1)) u4 (
      .clock(clock), .reset(reset), .enable(enable), .up_down(up_down), .load(load),
      .load_value(lv), .clear(clear), .value_out(v12[1]), .carry_out(d_c[4]),
      .borrow_out(d_b[4]), .overflow(d_o[4]), .at_max(d_mx[4]), .at_zero(d_z[4]));

   assign d_val[0] = 12'(v8[0]);
   assign d_val[1] = 12'(v8[1]);
   assign d_val[2] = 12'(v8[2]);
   assign d_val[3] = v12[0];
   assign d_val[4] = v12[1];

   task automatic chk(input string name, input int idx, input int unsigned act, input int unsigned exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (errors <= 30)
            $display("FAIL %s[u%0d] at %0t: got %0d expected %0d", name, idx, $time, act, exp);
      end
   endtask

   // Reference: counter rules applied with plain integer arithmetic over 0..MODULUS-1.
   always @(posedge clock or posedge reset) begin : model
      int unsigned lvi;
      for (int i = 0; i < N; i++) begin
         if (reset) begin
            m_val[i] = 0; m_c[i] = 1'b0; m_b[i] = 1'b0; m_o[i] = 1'b0;
         end else begin
            lvi = 32'(lv) % (32'd1 << p_w[i]);
            m_c[i] = 1'b0;
            m_b[i] = 1'b0;
            if (clear) begin
               m_val[i] = 0;
               m_o[i]   = 1'b0;
            end else if (load) begin
               m_val[i] = (lvi < p_mod[i]) ? lvi : p_mod[i] - 1;
            end else if (enable && up_down) begin
               if (m_val[i] < p_mod[i] - 1) m_val[i] = m_val[i] + 1;
               else if (p_sat[i]) m_o[i] = 1'b1;
               else begin m_val[i] = 0; m_c[i] = 1'b1; end
            end else if (enable) begin
               if (m_val[i] > 0) m_val[i] = m_val[i] - 1;
               else if (p_sat[i]) m_o[i] = 1'b1;
               else begin m_val[i] = p_mod[i] - 1; m_b[i] = 1'b1; end
            end
         end
      end
   end

   always @(negedge clock) begin
      if (chk_en) begin
         for (int i = 0; i < N; i++) begin
            chk("value", i, 32'(d_val[i]), m_val[i]);
            chk("carry", i, 32'(d_c[i]), 32'(m_c[i]));
            chk("borrow", i, 32'(d_b[i]), 32'(m_b[i]));
            chk("overflow", i, 32'(d_o[i]), 32'(m_o[i]));
            chk("at_max", i, 32'(d_mx[i]), 32'(m_val[i] == p_mod[i] - 1));
            chk("at_zero", i, 32'(d_z[i]), 32'(m_val[i] == 0));
            chk("carry_and_borrow", i, 32'(d_c[i] & d_b[i]), 0);
         end
      end
   end

   task automatic step(input bit e, input bit u, input bit l, input bit c, input int unsigned v);
      enable = e; up_down = u; load = l; clear = c; lv = 12'(v);
      @(negedge clock);
   endtask

   initial begin
      #1 reset = 1'b1;
      #1;
      chk("rst_value", 0, 32'(d_val[0]), 0);
      chk("rst_carry", 0, 32'(d_c[0]), 0);
      chk("rst_ovf", 2, 32'(d_o[2]), 0);
      chk_en = 1'b1;
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;

      // Reach 0x37, then pull reset between edges.
      step(0, 0, 1, 0, 'h36);
      step(1, 1, 0, 0, 0);
      chk("pre_rst_value", 0, 32'(d_val[0]), 'h37);
      chk("pre_rst_ovf", 2, 32'(d_o[2]), 1);
      #1 reset = 1'b1;
      #1;
      chk("async_rst_value", 0, 32'(d_val[0]), 0);
      chk("async_rst_carry", 0, 32'(d_c[0]), 0);
      chk("async_rst_ovf", 2, 32'(d_o[2]), 0);
      chk("async_rst_at_zero", 0, 32'(d_z[0]), 1);
      enable = 1'b0;
      #1 reset = 1'b0;
      @(negedge clock);

      // Full-range up-wrap.
      step(0, 0, 1, 0, 254);
      step(1, 1, 0, 0, 0);
      chk("upwrap_255", 0, 32'(d_val[0]), 255);
      chk("upwrap_at_max", 0, 32'(d_mx[0]), 1);
      chk("upwrap_no_carry", 0, 32'(d_c[0]), 0);
      step(1, 1, 0, 0, 0);
      chk("upwrap_0", 0, 32'(d_val[0]), 0);
      chk("upwrap_carry", 0, 32'(d_c[0]), 1);
      step(1, 1, 0, 0, 0);
      chk("upwrap_1", 0, 32'(d_val[0]), 1);
      chk("upwrap_carry_gone", 0, 32'(d_c[0]), 0);

      // Modulus 10 down-wrap and up-wrap.
      step(0, 0, 1, 0, 8);
      chk("m10_load8", 1, 32'(d_val[1]), 8);
      step(0, 0, 1, 0, 1);
      step(1, 0, 0, 0, 0);
      chk("m10_down_0", 1, 32'(d_val[1]), 0);
      chk("m10_down_0_borrow", 1, 32'(d_b[1]), 0);
      step(1, 0, 0, 0, 0);
      chk("m10_down_9", 1, 32'(d_val[1]), 9);
      chk("m10_borrow", 1, 32'(d_b[1]), 1);
      step(1, 0, 0, 0, 0);
      chk("m10_down_8", 1, 32'(d_val[1]), 8);
      chk("m10_borrow_gone", 1, 32'(d_b[1]), 0);
      step(0, 0, 1, 0, 9);
      step(1, 1, 0, 0, 0);
      chk("m10_up_0", 1, 32'(d_val[1]), 0);
      chk("m10_carry", 1, 32'(d_c[1]), 1);

      // Saturation at both ends, overflow sticky until clear.
      step(0, 0, 0, 1, 0);
      step(0, 0, 1, 0, 9);
      chk("sat_ovf_clean", 2, 32'(d_o[2]), 0);
      step(1, 1, 0, 0, 0);
      step(1, 1, 0, 0, 0);
      chk("sat_hold_9", 2, 32'(d_val[2]), 9);
      chk("sat_no_carry", 2, 32'(d_c[2]), 0);
      chk("sat_ovf", 2, 32'(d_o[2]), 1);
      step(0, 0, 1, 0, 3);
      chk("sat_ovf_after_load", 2, 32'(d_o[2]), 1);
      chk("sat_load3", 2, 32'(d_val[2]), 3);
      step(0, 0, 0, 1, 0);
      chk("sat_clear_value", 2, 32'(d_val[2]), 0);
      chk("sat_clear_ovf", 2, 32'(d_o[2]), 0);
      step(1, 0, 0, 0, 0);
      chk("sat_hold_0", 2, 32'(d_val[2]), 0);
      chk("sat_ovf_low", 2, 32'(d_o[2]), 1);
      chk("sat_no_borrow", 2, 32'(d_b[2]), 0);

      // Priority and clamp.
      step(0, 0, 1, 0, 7);
      step(1, 1, 1, 1, 5);
      chk("prio_clear", 1, 32'(d_val[1]), 0);
      step(0, 0, 1, 0, 200);
      chk("clamp_m10", 1, 32'(d_val[1]), 9);
      chk("load_200_m256", 0, 32'(d_val[0]), 200);

      // Random soak.
      for (int n = 0; n < 10000; n++) begin
         step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
              $urandom_range(0, 15) == 0, $urandom_range(0, 63) == 0,
              $urandom_range(0, 4095));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mod_updown_counter.md
Name: mod_updown_counter

Overview:
- Parametrised, fully synchronous up/down counter. It is the next generation of the 8-bit add-strobed counter.
- Width, modulus and overflow mode (wrap or saturate) are configurable.
- Adds a synchronous clear, parallel load, a direction control, and terminal-count and zero flags.
- Sits in datapath/timer logic. Increment and decrement go through a carry-lookahead incrementer sub-module, not the `+` operator.

Parameters:
- WIDTH, 8, counter width in bits (2..32).
- MODULUS, 256, count range 0..MODULUS-1. Constraint 2 <= MODULUS <= 2**WIDTH.
- SATURATE, 0, 0 = wrap at the range ends, 1 = hold at the range ends.

Ports:
- clock, input, 1, rising-edge clock.
- reset, input, 1, asynchronous active-high reset.
- enable, input, 1, count strobe: one step per clock while high.
- up_down, input, 1, 1 = count up, 0 = count down.
- load, input, 1, synchronous parallel load.
- load_value, input, WIDTH, value to load.
- clear, input, 1, synchronous clear to 0.
- value_out, output, WIDTH, current count (registered).
- carry_out, output, 1, one-cycle pulse on up-wrap (registered).
- borrow_out, output, 1, one-cycle pulse on down-wrap (registered).
- overflow, output, 1, sticky flag: a saturate-mode count was blocked at a range end.
- at_max, output, 1, value_out == MODULUS-1 (combinational from the register).
- at_zero, output, 1, value_out == 0 (combinational from the register).

Behaviour:
- One clock; reset is asynchronous and active-high. While reset=1: value_out=0, carry_out=0, borrow_out=0, overflow=0. Counting resumes on the first rising clock after reset deasserts.
- All other state changes on the rising edge of clock. Latency is 1 cycle from input to value_out.
- Priority per cycle: clear > load > enable. At most one action per cycle.
- clear=1: value_out<=0, overflow<=0, carry/borrow pulses <=0.
- load=1 (and no clear): value_out<=load_value if load_value < MODULUS, else MODULUS-1 (clamped). overflow unchanged; pulses <=0.
- enable=1, up_down=1:
  - value < MODULUS-1: value+1.
  - value == MODULUS-1 and SATURATE=0: value<=0, carry_out<=1 for one cycle.
  - value == MODULUS-1 and SATURATE=1: value held, carry_out stays 0, overflow<=1.
- enable=1, up_down=0:
  - value > 0: value-1.
  - value == 0 and SATURATE=0: value<=MODULUS-1, borrow_out<=1 for one cycle.
  - value == 0 and SATURATE=1: value held, overflow<=1.
- enable=0 with no clear/load: value held, pulses <=0.
- carry_out and borrow_out are never high in the same cycle. Each is high for exactly one cycle per wrap. Back-to-back wraps (e.g. MODULUS=2, continuous enable) give a pulse every other cycle, aligned with the value reaching 0 (up) or MODULUS-1 (down).
- Width rules:
  - Incrementer computes the step as WIDTH-bit value plus 1, or plus all-ones for decrement, with its carry-in used.
  - When MODULUS == 2**WIDTH, the natural adder carry-out equals the wrap condition. Otherwise wrap is detected by compare against MODULUS-1.
- If reset is asserted mid-count, state is lost immediately; no pulse is emitted.
- Direction changes take effect on the same edge; no pipeline hazard.

Decomposition:
- Shared package: typedef count_t (logic [WIDTH-1:0] via parameterised use), localparam MAX_VAL = MODULUS-1, mode constants MODE_WRAP=0 and MODE_SAT=1.
- One sub-module: cla_incdec, parametrised WIDTH.
  - Inputs: operand, dec (1 = subtract one), cin.
  - Outputs: result, cout.
  - Carry-lookahead in 4-bit groups with group-generate/propagate, no `+` operator.
- Top holds the register, priority mux, wrap/saturate compare and flag logic.

Test Plan:
- Reset: WIDTH=8, MODULUS=256, SATURATE=0. Assert reset mid-count at value 0x37 → value_out=0, carry_out=0, overflow=0 asynchronously, before the next clock edge.
- Up-wrap: load 254, enable up 3 cycles → values 255, 0, 1; carry_out=1 only in the cycle value_out=0; at_max=1 at 255.
- Non-power-of-two wrap: MODULUS=10, load 8, count down from 1 → values 0, 9, 8; borrow_out pulses once at 9; count up from 9 → 0 with carry_out pulse.
- Saturate: SATURATE=1, MODULUS=10, load 9, enable up 2 cycles → value stays 9, carry_out never 1, overflow=1 and stays 1 until clear; clear → value 0, overflow 0.
- Priority and clamp: clear, load and enable asserted together with load_value=5 → value 0; load alone with load_value=200 at MODULUS=10 → value 9.
- Random soak: WIDTH=12, MODULUS=3000, 10k cycles of random enable/up_down/load/clear checked against a scoreboard model; no cycle has carry_out and borrow_out both high.
